// File: rtl/vga_sprite_engine.sv
// Keyboard-driven multi-sprite overlay between the VGA timing generator and the pins.
// Optional sprite-overlap detection is built when VGA_SPRITE_COLLISION_EN is defined.
module vga_sprite_engine #(
  parameter int NUM_SPRITES = 2,
  parameter int SPRITE_W    = 50,
  parameter int SPRITE_H    = 50,
  parameter int STEP        = 1,
  parameter int H_RES       = 640,
  parameter int V_RES       = 480,
  parameter int COLOR_W     = 12,
  // Sprite 0 sits in the low bits: sprite 0 green, sprite 1 red.
  parameter logic [NUM_SPRITES*COLOR_W-1:0] SPRITE_COLORS = {12'hA00, 12'h0A0}
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               active,
  input  logic               screenEnd,
  input  logic [9:0]         x,
  input  logic [8:0]         y,
  input  logic [COLOR_W-1:0] bgColor,
  input  logic [7:0]         scanCode,
  input  logic               scanDone,
  output logic [COLOR_W-1:0] rgbOut,
  output logic [2:0]         selSprite,
  output logic               collision
);

  localparam logic [10:0] X_MAX    = 11'(H_RES - SPRITE_W);
  localparam logic [10:0] Y_MAX    = 11'(V_RES - SPRITE_H);
  localparam logic [10:0] STEP_11  = 11'(STEP);
  localparam logic [10:0] W_11     = 11'(SPRITE_W);
  localparam logic [10:0] H_11     = 11'(SPRITE_H);
  localparam logic [2:0]  LAST_SEL = 3'(NUM_SPRITES - 1);

  typedef enum logic [1:0] {DEC_IDLE, DEC_BRK, DEC_EXT, DEC_EXT_BRK} dec_state_t;

  dec_state_t dec_state, dec_state_nx;
  logic key_w, key_s, key_a, key_d, tab_held;
  logic key_w_nx, key_s_nx, key_a_nx, key_d_nx, tab_held_nx;
  logic [2:0] sel_nx;
  logic se_d, tick;

  // Positions are kept 11 bits wide so step and clamp arithmetic never wraps.
  logic [10:0] sx    [NUM_SPRITES];
  logic [10:0] sy    [NUM_SPRITES];
  logic [10:0] sx_nx [NUM_SPRITES];
  logic [10:0] sy_nx [NUM_SPRITES];
  logic [10:0] cx, cy;

  logic [NUM_SPRITES-1:0] hit;
  logic [COLOR_W-1:0]     pix_color;
  logic [10:0]            pix_x, pix_y;

  assign tick  = screenEnd && !se_d;
  assign pix_x = {1'b0, x};
  assign pix_y = {2'b0, y};

  // PS/2 set-2 decoder: only scanDone strobes advance it.
  always_comb begin
    dec_state_nx = dec_state;
    key_w_nx     = key_w;
    key_s_nx     = key_s;
    key_a_nx     = key_a;
    key_d_nx     = key_d;
    tab_held_nx  = tab_held;
    sel_nx       = selSprite;
    if (scanDone) begin
      case (dec_state)
        DEC_IDLE: begin
          case (scanCode)
            8'hF0: dec_state_nx = DEC_BRK;
            8'hE0: dec_state_nx = DEC_EXT;
            8'h1D: key_w_nx = 1'b1;
            8'h1B: key_s_nx = 1'b1;
            8'h1C: key_a_nx = 1'b1;
            8'h23: key_d_nx = 1'b1;
            8'h0D: begin
              tab_held_nx = 1'b1;
              if (!tab_held) sel_nx = (selSprite == LAST_SEL) ? 3'd0 : selSprite + 3'd1;
            end
            default: ;
          endcase
        end
        DEC_BRK: begin
          case (scanCode)
            8'h1D: key_w_nx = 1'b0;
            8'h1B: key_s_nx = 1'b0;
            8'h1C: key_a_nx = 1'b0;
            8'h23: key_d_nx = 1'b0;
            8'h0D: tab_held_nx = 1'b0;
            default: ;
          endcase
          dec_state_nx = DEC_IDLE;
        end
        DEC_EXT:     dec_state_nx = (scanCode == 8'hF0) ? DEC_EXT_BRK : DEC_IDLE;
        DEC_EXT_BRK: dec_state_nx = DEC_IDLE;
        default:     dec_state_nx = DEC_IDLE;
      endcase
    end
  end

  // Movement of the currently selected sprite on the frame tick.
  always_comb begin
    cx = '0;
    cy = '0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      sx_nx[i] = sx[i];
      sy_nx[i] = sy[i];
      if (tick && selSprite == 3'(i)) begin
        cx = sx[i];
        cy = sy[i];
        if (key_a && !key_d)      cx = (cx < STEP_11) ? 11'd0 : cx - STEP_11;
        else if (key_d && !key_a) cx = (cx + STEP_11 > X_MAX) ? X_MAX : cx + STEP_11;
        if (key_w && !key_s)      cy = (cy < STEP_11) ? 11'd0 : cy - STEP_11;
        else if (key_s && !key_w) cy = (cy + STEP_11 > Y_MAX) ? Y_MAX : cy + STEP_11;
        sx_nx[i] = cx;
        sy_nx[i] = cy;
      end
    end
  end

  // Descending scan so the lowest-index hit determines the colour.
  always_comb begin
    hit       = '0;
    pix_color = bgColor;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      hit[i] = (pix_x >= sx[i]) && (pix_x < sx[i] + W_11) &&
               (pix_y >= sy[i]) && (pix_y < sy[i] + H_11);
      if (hit[i]) pix_color = SPRITE_COLORS[i*COLOR_W +: COLOR_W];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dec_state <= DEC_IDLE;
      key_w     <= 1'b0;
      key_s     <= 1'b0;
      key_a     <= 1'b0;
      key_d     <= 1'b0;
      tab_held  <= 1'b0;
      selSprite <= 3'd0;
      se_d      <= 1'b1;
      rgbOut    <= '0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        sx[i] <= 11'(i * SPRITE_W);
        sy[i] <= 11'd0;
      end
    end else begin
      dec_state <= dec_state_nx;
      key_w     <= key_w_nx;
      key_s     <= key_s_nx;
      key_a     <= key_a_nx;
      key_d     <= key_d_nx;
      tab_held  <= tab_held_nx;
      selSprite <= sel_nx;
      se_d      <= screenEnd;
      rgbOut    <= active ? pix_color : '0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        sx[i] <= sx_nx[i];
        sy[i] <= sy_nx[i];
      end
    end
  end

`ifdef VGA_SPRITE_COLLISION_EN
  localparam logic [NUM_SPRITES-1:0] ONE = NUM_SPRITES'(1);
  logic coll_flag;
  logic multi_hit;

  // More than one bit set in hit means at least two sprites cover this pixel.
  assign multi_hit = (hit & (hit - ONE)) != '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      coll_flag <= 1'b0;
      collision <= 1'b0;
    end else if (tick) begin
      collision <= coll_flag;
      coll_flag <= 1'b0;
    end else if (active && multi_hit) begin
      coll_flag <= 1'b1;
    end
  end
`else
  assign collision = 1'b0;
`endif

endmodule

// File: tb/tb_vga_sprite_engine.sv
// Directed bench for vga_sprite_engine: decoder, movement, clamping, compositing, collision.
module tb_vga_sprite_engine;

  localparam logic [11:0] BG  = 12'h123;
  localparam logic [11:0] GRN = 12'h0A0;
  localparam logic [11:0] RED = 12'hA00;
`ifdef VGA_SPRITE_COLLISION_EN
  localparam logic COLL_EN = 1'b1;
`else
  localparam logic COLL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        active;
  logic        screenEnd;
  logic [9:0]  x;
  logic [8:0]  y;
  logic [11:0] bgColor;
  logic [7:0]  scanCode;
  logic        scanDone;
  logic [11:0] rgbOut;
  logic [2:0]  selSprite;
  logic        collision;

  int n_tests = 0;
  int n_fail  = 0;

  vga_sprite_engine dut (
    .clk       (clk),
    .reset     (reset),
    .active    (active),
    .screenEnd (screenEnd),
    .x         (x),
    .y         (y),
    .bgColor   (bgColor),
    .scanCode  (scanCode),
    .scanDone  (scanDone),
    .rgbOut    (rgbOut),
    .selSprite (selSprite),
    .collision (collision)
  );

  // clock / reset
  always #5 clk = ~clk;

  // driver tasks: inputs change on the falling edge, outputs are read there too
  task automatic send_code(input logic [7:0] c);
    @(negedge clk);
    scanCode = c;
    scanDone = 1'b1;
    @(negedge clk);
    scanDone = 1'b0;
  endtask

  task automatic frame(input int hold);
    @(negedge clk);
    screenEnd = 1'b1;
    repeat (hold) @(negedge clk);
    screenEnd = 1'b0;
    @(negedge clk);
  endtask

  task automatic probe(input logic [9:0] px, input logic [8:0] py, input logic act,
                       output logic [11:0] got);
    @(negedge clk);
    x = px;
    y = py;
    active = act;
    @(negedge clk);
    got = rgbOut;
    active = 1'b0;
  endtask

  task automatic test_reset();
    logic [11:0] got;
    logic [9:0]  px[6] = '{10'd0, 10'd49, 10'd50, 10'd99, 10'd100, 10'd0};
    logic [8:0]  py[6] = '{9'd0, 9'd0, 9'd0, 9'd49, 9'd0, 9'd50};
    logic [11:0] ex[6] = '{GRN, GRN, RED, RED, BG, BG};
    x = 10'd0; y = 9'd0; active = 1'b1;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if (rgbOut !== 12'h000) begin n_fail++; $display("FAIL reset_rgb: got %h expected 000", rgbOut); end
    n_tests++;
    if (selSprite !== 3'd0) begin n_fail++; $display("FAIL reset_sel: got %0d expected 0", selSprite); end
    n_tests++;
    if (collision !== 1'b0) begin n_fail++; $display("FAIL reset_coll: got %b expected 0", collision); end
    reset = 1'b0;
    active = 1'b0;
    for (int i = 0; i < 6; i++) begin
      probe(px[i], py[i], 1'b1, got);
      n_tests++;
      if (got !== ex[i]) begin
        n_fail++;
        $display("FAIL reset_pix(%0d,%0d): got %h expected %h", px[i], py[i], got, ex[i]);
      end
    end
  endtask

  task automatic test_move_clamp();
    logic [11:0] got;
    logic [9:0]  px[6] = '{10'd4, 10'd5, 10'd54, 10'd55, 10'd99, 10'd100};
    logic [11:0] ex[6] = '{BG, GRN, GRN, RED, RED, BG};
    send_code(8'h1C);
    repeat (3) frame(1);
    probe(10'd0, 9'd0, 1'b1, got);
    n_tests++;
    if (got !== GRN) begin n_fail++; $display("FAIL clamp_left: got %h expected %h", got, GRN); end
    send_code(8'hF0); send_code(8'h1C);
    send_code(8'h23);
    repeat (5) frame(1);
    send_code(8'hF0); send_code(8'h23);
    for (int i = 0; i < 6; i++) begin
      probe(px[i], 9'd0, 1'b1, got);
      n_tests++;
      if (got !== ex[i]) begin
        n_fail++;
        $display("FAIL move_right(%0d,0): got %h expected %h", px[i], got, ex[i]);
      end
    end
  endtask

  task automatic test_tab_select();
    logic [11:0] got;
    logic [9:0]  px[3] = '{10'd100, 10'd101, 10'd4};
    logic [11:0] ex[3] = '{RED, BG, BG};
    send_code(8'h0D); send_code(8'h0D); send_code(8'hF0); send_code(8'h0D);
    n_tests++;
    if (selSprite !== 3'd1) begin n_fail++; $display("FAIL tab_once: got %0d expected 1", selSprite); end
    send_code(8'h23);
    frame(1);
    send_code(8'hF0); send_code(8'h23);
    for (int i = 0; i < 3; i++) begin
      probe(px[i], 9'd0, 1'b1, got);
      n_tests++;
      if (got !== ex[i]) begin
        n_fail++;
        $display("FAIL sel_move(%0d,0): got %h expected %h", px[i], got, ex[i]);
      end
    end
    send_code(8'h0D); send_code(8'hF0); send_code(8'h0D);
    n_tests++;
    if (selSprite !== 3'd0) begin n_fail++; $display("FAIL tab_wrap: got %0d expected 0", selSprite); end
  endtask

  task automatic test_extended();
    logic [11:0] got;
    logic [8:0]  py[4] = '{9'd1, 9'd2, 9'd51, 9'd52};
    logic [11:0] ex[4] = '{BG, GRN, GRN, BG};
    send_code(8'hE0); send_code(8'hF0); send_code(8'h1D);
    send_code(8'hE0); send_code(8'hF0); send_code(8'h1B);
    send_code(8'hE0); send_code(8'h75);
    send_code(8'hE0); send_code(8'h1B);
    frame(1);
    probe(10'd5, 9'd49, 1'b1, got);
    n_tests++;
    if (got !== GRN) begin n_fail++; $display("FAIL ext_nomove_in: got %h expected %h", got, GRN); end
    probe(10'd5, 9'd50, 1'b1, got);
    n_tests++;
    if (got !== BG) begin n_fail++; $display("FAIL ext_nomove_out: got %h expected %h", got, BG); end
    send_code(8'h1B);
    repeat (2) frame(1);
    for (int i = 0; i < 4; i++) begin
      probe(10'd5, py[i], 1'b1, got);
      n_tests++;
      if (got !== ex[i]) begin
        n_fail++;
        $display("FAIL move_down(5,%0d): got %h expected %h", py[i], got, ex[i]);
      end
    end
  endtask

  task automatic test_long_screen_end();
    logic [11:0] got;
    frame(8);
    send_code(8'hF0); send_code(8'h1B);
    probe(10'd5, 9'd2, 1'b1, got);
    n_tests++;
    if (got !== BG) begin n_fail++; $display("FAIL long_tick_top: got %h expected %h", got, BG); end
    probe(10'd5, 9'd3, 1'b1, got);
    n_tests++;
    if (got !== GRN) begin n_fail++; $display("FAIL long_tick_in: got %h expected %h", got, GRN); end
    probe(10'd5, 9'd3, 1'b0, got);
    n_tests++;
    if (got !== 12'h000) begin n_fail++; $display("FAIL blank: got %h expected 000", got); end
  endtask

  task automatic test_collision();
    logic [11:0] got;
    logic [9:0]  px[3] = '{10'd49, 10'd50, 10'd51};
    logic [11:0] ex[3] = '{GRN, BG, RED};
    probe(10'd52, 9'd10, 1'b1, got);
    n_tests++;
    if (got !== GRN) begin n_fail++; $display("FAIL overlap_pix: got %h expected %h", got, GRN); end
    frame(1);
    n_tests++;
    if (collision !== COLL_EN) begin n_fail++; $display("FAIL coll_set: got %b expected %b", collision, COLL_EN); end
    probe(10'd55, 9'd10, 1'b1, got);
    repeat (20) @(negedge clk);
    n_tests++;
    if (got !== RED || collision !== COLL_EN) begin
      n_fail++;
      $display("FAIL coll_hold: got %h/%b expected %h/%b", got, collision, RED, COLL_EN);
    end
    frame(1);
    n_tests++;
    if (collision !== 1'b0) begin n_fail++; $display("FAIL coll_clear: got %b expected 0", collision); end
    send_code(8'h1C);
    repeat (5) frame(1);
    send_code(8'hF0); send_code(8'h1C);
    for (int i = 0; i < 3; i++) begin
      probe(px[i], 9'd10, 1'b1, got);
      n_tests++;
      if (got !== ex[i]) begin
        n_fail++;
        $display("FAIL separated(%0d,10): got %h expected %h", px[i], got, ex[i]);
      end
    end
    frame(1);
    n_tests++;
    if (collision !== 1'b0) begin n_fail++; $display("FAIL coll_separated: got %b expected 0", collision); end
  endtask

  task automatic test_midframe_reset();
    logic [11:0] got;
    logic [9:0]  px[3] = '{10'd0, 10'd50, 10'd0};
    logic [8:0]  py[3] = '{9'd0, 9'd0, 9'd50};
    logic [11:0] ex[3] = '{GRN, RED, BG};
    send_code(8'h23);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    frame(1);
    for (int i = 0; i < 3; i++) begin
      probe(px[i], py[i], 1'b1, got);
      n_tests++;
      if (got !== ex[i]) begin
        n_fail++;
        $display("FAIL midreset(%0d,%0d): got %h expected %h", px[i], py[i], got, ex[i]);
      end
    end
  endtask

  initial begin
    reset = 1'b1; active = 1'b0; screenEnd = 1'b0;
    x = '0; y = '0; bgColor = BG; scanCode = '0; scanDone = 1'b0;
    test_reset();
    test_move_clamp();
    test_tab_select();
    test_extended();
    test_long_screen_end();
    test_collision();
    test_midframe_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
